// File: rtl/mem_stage_if.sv
// Execute-to-memory, SRAM/multiplier return and memory-to-write-back signals of the mem stage.
// Master is the surrounding pipeline; slave is the mem stage itself.
interface mem_stage_if;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [109:0] ex_to_mem_wire;
  logic [31:0]  data_sram_rdata;
  logic [63:0]  mul_result;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_wire;
  logic [37:0]  mem_rf_zip;

  modport master (
    output ex_to_mem_valid, ex_to_mem_wire, data_sram_rdata, mul_result, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_wire, mem_rf_zip
  );

  modport slave (
    input  ex_to_mem_valid, ex_to_mem_wire, data_sram_rdata, mul_result, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_wire, mem_rf_zip
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: registers the execute bus and forms the write-back value, one cycle of occupancy minimum.
// Stalls on wb_allowin = 0; late SRAM/multiplier data is captured in its fresh cycle so it survives stalls.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        ld_w;
    logic        res_from_mul;
    logic        mul_h;
    logic        res_from_div;
    logic [31:0] div_result;
  } ex_bus_t;

  ex_bus_t     bus_q;
  logic        mem_valid;
  logic        fresh;
  logic [31:0] rdata_hold;
  logic [63:0] mul_hold;
  logic        mem_ready_go;
  logic        mem_allowin;

  assign mem_ready_go = 1'b1;
  assign mem_allowin  = ~mem_valid | bus.wb_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      fresh      <= 1'b0;
      bus_q      <= '0;
      rdata_hold <= '0;
      mul_hold   <= '0;
    end else begin
      if (mem_allowin) begin
        mem_valid <= bus.ex_to_mem_valid;
      end
      if (bus.ex_to_mem_valid && mem_allowin) begin
        bus_q <= bus.ex_to_mem_wire;
        fresh <= 1'b1;
      end else begin
        fresh <= 1'b0;
      end
      // The SRAM and multiplier only drive valid data in the fresh cycle.
      if (fresh && mem_valid) begin
        rdata_hold <= bus.data_sram_rdata;
        mul_hold   <= bus.mul_result;
      end
    end
  end

  logic [31:0] rdata_eff;
  logic [63:0] mul_eff;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] mul_val;
  logic [31:0] final_result;
  logic        any_ld;

  assign rdata_eff = fresh ? bus.data_sram_rdata : rdata_hold;
  assign mul_eff   = fresh ? bus.mul_result : mul_hold;
  assign ld_half   = bus_q.alu_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];
  assign mul_val   = bus_q.mul_h ? mul_eff[63:32] : mul_eff[31:0];
  assign any_ld    = bus_q.ld_b | bus_q.ld_bu | bus_q.ld_h | bus_q.ld_hu | bus_q.ld_w;

  always_comb begin
    ld_byte = rdata_eff[7:0];
    case (bus_q.alu_result[1:0])
      2'd0: ld_byte = rdata_eff[7:0];
      2'd1: ld_byte = rdata_eff[15:8];
      2'd2: ld_byte = rdata_eff[23:16];
      2'd3: ld_byte = rdata_eff[31:24];
      default: ld_byte = rdata_eff[7:0];
    endcase
  end

  always_comb begin
    load_val = rdata_eff;
    if (bus_q.ld_b) begin
      load_val = {{24{ld_byte[7]}}, ld_byte};
    end else if (bus_q.ld_bu) begin
      load_val = {24'd0, ld_byte};
    end else if (bus_q.ld_h) begin
      load_val = {{16{ld_half[15]}}, ld_half};
    end else if (bus_q.ld_hu) begin
      load_val = {16'd0, ld_half};
    end
  end

  always_comb begin
    final_result = bus_q.alu_result;
    if (any_ld) begin
      final_result = load_val;
    end else if (bus_q.res_from_mul) begin
      final_result = mul_val;
    end else if (bus_q.res_from_div) begin
      final_result = bus_q.div_result;
    end
  end

  assign bus.mem_allowin     = mem_allowin;
  assign bus.mem_to_wb_valid = mem_valid & mem_ready_go;
  assign bus.mem_to_wb_wire  = {bus_q.rf_we, bus_q.rf_waddr, bus_q.pc, final_result};
  assign bus.mem_rf_zip      = {bus_q.rf_we & mem_valid, bus_q.rf_waddr, final_result};

endmodule
